ecc_pmul_ctrl: RTL

- Sequencer for ECC scalar point multiplication Q = k·P, using left-to-right double-and-add.
- Sits between the ECC serial I/O wrapper and the shared point-arithmetic unit (point double / point add).
- Latches scalar k and field-width mode, skips leading zero bits, then issues DOUBLE and ADD operations to the arithmetic unit over a req/ack handshake.
- Reports completion, and reports point-at-infinity when k = 0.

---
 rtl/ecc_pmul_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ecc_pmul_ctrl.sv
// rtl/ecc_pmul_ctrl.sv - left-to-right double-and-add sequencer for ECC scalar point multiplication
module ecc_pmul_ctrl #(
  parameter int MAX_BITS = 256,
  parameter int IDX_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [MAX_BITS-1:0] i_k,
  output logic                o_busy,
  output logic                o_acc_init,
  output logic                o_op_req,
  output logic                o_op_sel,
  input  logic                i_op_ack,
  output logic [IDX_W-1:0]    o_bit_idx,
  output logic                o_done,
  output logic                o_inf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_INIT,
    S_DBL,
    S_ADD,
    S_DONE
  } state_t;

  // Highest usable bit index for a width mode, clamped to what this instance can hold.
  function automatic logic [IDX_W-1:0] f_top_idx(input logic [1:0] mode);
    logic [IDX_W+1:0] v_width;
    v_width = (IDX_W+2)'(32) << mode;
    if (v_width > (IDX_W+2)'(MAX_BITS)) begin
      v_width = (IDX_W+2)'(MAX_BITS);
    end
    return IDX_W'(v_width - (IDX_W+2)'(1));
  endfunction

  state_t              r_state;
  logic [MAX_BITS-1:0] r_k;
  logic [1:0]          r_mode;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_acc_init;
  logic                r_op_req;
  logic                r_op_sel;
  logic                r_done;
  logic                r_inf;

  logic                w_kbit;
  logic                w_idx_zero;
  logic [IDX_W-1:0]    w_idx_dec;

  // Bits above the latched width read as zero, so out-of-width scalar bits never count.
  assign w_kbit     = r_k[r_idx] & (r_idx <= f_top_idx(r_mode));
  assign w_idx_zero = (r_idx == '0);
  assign w_idx_dec  = r_idx - IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_mode     <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_acc_init <= 1'b0;
      r_op_req   <= 1'b0;
      r_op_sel   <= 1'b0;
      r_done     <= 1'b0;
      r_inf      <= 1'b0;
    end else begin
      r_acc_init <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k     <= i_k;
            r_mode  <= i_mode;
            r_inf   <= 1'b0;
            r_idx   <= f_top_idx(i_mode);
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_kbit) begin
            r_acc_init <= 1'b1;
            r_state    <= S_INIT;
          end else if (w_idx_zero) begin
            r_inf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= w_idx_dec;
          end
        end
        S_INIT: begin
          if (w_idx_zero) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx    <= w_idx_dec;
            r_op_req <= 1'b1;
            r_op_sel <= 1'b0;
            r_state  <= S_DBL;
          end
        end
        S_DBL: begin
          if (i_op_ack) begin
            if (w_kbit) begin
              r_op_sel <= 1'b1;
              r_state  <= S_ADD;
            end else if (w_idx_zero) begin
              r_op_req <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx <= w_idx_dec;
            end
          end
        end
        S_ADD: begin
          if (i_op_ack) begin
            if (w_idx_zero) begin
              r_op_req <= 1'b0;
              r_op_sel <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx    <= w_idx_dec;
              r_op_sel <= 1'b0;
              r_state  <= S_DBL;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_op_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_acc_init = r_acc_init;
  assign o_op_req   = r_op_req;
  assign o_op_sel   = r_op_sel;
  assign o_bit_idx  = r_idx;
  assign o_done     = r_done;
  assign o_inf      = r_inf;

endmodule
